// File: rtl/lru_pkg.sv
// lru_pkg: shared opcode type and index-width helper for the LRU tracker
package lru_pkg;
  typedef enum logic [1:0] {
    TOUCH = 2'd0,
    INVAL = 2'd1,
    ALLOC = 2'd2,
    RSVD  = 2'd3
  } lru_op_e;
  function automatic int idx_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/lru_tracker_if.sv
// lru_tracker_if: command, lock and response signals between a tag controller and the tracker
interface lru_tracker_if import lru_pkg::*; #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = idx_w(WAYS)
);
  logic             cmd_v_i;
  lru_op_e          cmd_op_i;
  logic [IDX_W-1:0] cmd_idx_i;
  logic [WAYS-1:0]  lock_i;
  logic [IDX_W-1:0] victim_o;
  logic             victim_v_o;
  logic             alloc_v_o;
  logic [IDX_W-1:0] alloc_idx_o;
  logic             err_o;
  modport master (
    output cmd_v_i, cmd_op_i, cmd_idx_i, lock_i,
    input  victim_o, victim_v_o, alloc_v_o, alloc_idx_o, err_o
  );
  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_idx_i, lock_i,
    output victim_o, victim_v_o, alloc_v_o, alloc_idx_o, err_o
  );
endinterface

// File: rtl/lru_victim_sel.sv
// lru_victim_sel: combinational oldest-unlocked-entry search over the age permutation
module lru_victim_sel import lru_pkg::*; #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = idx_w(WAYS)
) (
  input  logic [IDX_W-1:0] age_i [WAYS],
  input  logic [WAYS-1:0]  lock_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             v_o
);
  logic [IDX_W-1:0] best_age;
  logic             found;
  always_comb begin
    idx_o    = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!lock_i[i] && (!found || age_i[i] > best_age)) begin
        idx_o    = IDX_W'(i);
        best_age = age_i[i];
        found    = 1'b1;
      end
    end
    v_o = found;
  end
endmodule

// File: rtl/lru_tracker.sv
// lru_tracker: full-order LRU tracker with lock mask, touch/invalidate/allocate commands
module lru_tracker import lru_pkg::*; #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = idx_w(WAYS)
) (
  input logic          clk,
  input logic          rst,
  lru_tracker_if.slave bus
);
  logic [IDX_W-1:0] age_q [WAYS];
  logic [IDX_W-1:0] age_d [WAYS];
  logic [IDX_W-1:0] vic, tgt, ta, alloc_idx_q;
  logic             vic_v, idx_ok, do_touch, do_inval, do_alloc, err_d;
  logic             alloc_v_q, err_q;
  lru_victim_sel #(.WAYS(WAYS)) u_sel (
    .age_i  (age_q),
    .lock_i (bus.lock_i),
    .idx_o  (vic),
    .v_o    (vic_v)
  );
  assign idx_ok   = int'(bus.cmd_idx_i) < WAYS;
  assign do_touch = bus.cmd_v_i && bus.cmd_op_i == TOUCH && idx_ok;
  assign do_inval = bus.cmd_v_i && bus.cmd_op_i == INVAL && idx_ok;
  assign do_alloc = bus.cmd_v_i && bus.cmd_op_i == ALLOC && vic_v;
  assign err_d    = bus.cmd_v_i && !(do_touch || do_inval || do_alloc);
  assign tgt      = do_alloc ? vic : bus.cmd_idx_i;
  // ALLOC is a TOUCH of the victim; ages stay a permutation so +1/-1 never wraps
  always_comb begin
    ta = '0;
    for (int i = 0; i < WAYS; i++) ta = (IDX_W'(i) == tgt) ? age_q[i] : ta;
    for (int i = 0; i < WAYS; i++)
      age_d[i] = (do_touch || do_alloc) ? ((IDX_W'(i) == tgt) ? '0 : age_q[i] + IDX_W'(age_q[i] < ta)) :
                 do_inval ? ((IDX_W'(i) == tgt) ? IDX_W'(WAYS - 1) : age_q[i] - IDX_W'(age_q[i] > ta)) :
                 age_q[i];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WAYS; i++) age_q[i] <= IDX_W'(WAYS - 1 - i);
      alloc_v_q   <= 1'b0;
      alloc_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      age_q     <= age_d;
      alloc_v_q <= do_alloc;
      if (do_alloc) alloc_idx_q <= vic;
      err_q     <= err_d;
    end
  end
  assign bus.victim_o    = vic;
  assign bus.victim_v_o  = vic_v;
  assign bus.alloc_v_o   = alloc_v_q;
  assign bus.alloc_idx_o = alloc_idx_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_lru_tracker.sv
// tb_lru_tracker: scoreboard bench over WAYS=4, 5 and 8 tracker instances
module tb_lru_tracker;
  import lru_pkg::*;
  typedef struct {int d; bit al; int idx; int due;} exp_t;
  logic clk = 1'b0, clk_en = 1'b1, rst = 1'b0, run = 1'b0;
  int checks = 0, failures = 0, cyc = 0;
  logic    cv [3];
  lru_op_e cop [3];
  int      cidx [3];
  logic [7:0] lk [3];
  int ord [3][8];
  exp_t sb [$];
  logic av [3], er [3], vvo [3];
  int ai [3], vo [3], ag [3][8];
  always #5 clk = clk_en ? ~clk : clk;
  always @(posedge clk) cyc <= cyc + 1;
  lru_tracker_if #(.WAYS(4)) ifa ();
  lru_tracker_if #(.WAYS(5)) ifb ();
  lru_tracker_if #(.WAYS(8)) ifc ();
  lru_tracker #(.WAYS(4)) u4 (.clk(clk), .rst(rst), .bus(ifa.slave));
  lru_tracker #(.WAYS(5)) u5 (.clk(clk), .rst(rst), .bus(ifb.slave));
  lru_tracker #(.WAYS(8)) u8 (.clk(clk), .rst(rst), .bus(ifc.slave));
  assign ifa.cmd_v_i = cv[0];
  assign ifa.cmd_op_i = cop[0];
  assign ifa.cmd_idx_i = 2'(cidx[0]);
  assign ifa.lock_i = lk[0][3:0];
  assign ifb.cmd_v_i = cv[1];
  assign ifb.cmd_op_i = cop[1];
  assign ifb.cmd_idx_i = 3'(cidx[1]);
  assign ifb.lock_i = lk[1][4:0];
  assign ifc.cmd_v_i = cv[2];
  assign ifc.cmd_op_i = cop[2];
  assign ifc.cmd_idx_i = 3'(cidx[2]);
  assign ifc.lock_i = lk[2];
  function automatic int nw(int d);
    return d == 0 ? 4 : d == 1 ? 5 : 8;
  endfunction
  // reference model: ord[d][k] is the entry whose age is k (k=0 is MRU)
  function automatic int mvictim(int d);
    for (int k = nw(d) - 1; k >= 0; k--) if (!lk[d][ord[d][k]]) return ord[d][k];
    return -1;
  endfunction
  function automatic int mpos(int d, int e);
    for (int k = 0; k < nw(d); k++) if (ord[d][k] == e) return k;
    return 0;
  endfunction
  function automatic void mtouch(int d, int e);
    for (int k = mpos(d, e); k > 0; k--) ord[d][k] = ord[d][k-1];
    ord[d][0] = e;
  endfunction
  function automatic void minval(int d, int e);
    for (int k = mpos(d, e); k < nw(d) - 1; k++) ord[d][k] = ord[d][k+1];
    ord[d][nw(d)-1] = e;
  endfunction
  function automatic void mreset();
    for (int d = 0; d < 3; d++) for (int k = 0; k < nw(d); k++) ord[d][k] = nw(d) - 1 - k;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    mreset();
    rst = 1'b1;
  endtask
  task automatic issue(int d, lru_op_e op, int idx);
    int v;
    cv[d] = 1'b1; cop[d] = op; cidx[d] = idx;
    v = mvictim(d);
    if (op == ALLOC && v >= 0) sb.push_back('{d, 1'b1, v, cyc + 1});
    else if (op == RSVD || op == ALLOC || idx >= nw(d)) sb.push_back('{d, 1'b0, 0, cyc + 1});
    @(posedge clk); #1;
    if (op == TOUCH && idx < nw(d)) mtouch(d, idx);
    if (op == INVAL && idx < nw(d)) minval(d, idx);
    if (op == ALLOC && v >= 0) mtouch(d, v);
    cv[d] = 1'b0;
  endtask
  always @(negedge clk) if (run) begin
    av[0] = ifa.alloc_v_o; ai[0] = int'(ifa.alloc_idx_o); er[0] = ifa.err_o; vo[0] = int'(ifa.victim_o); vvo[0] = ifa.victim_v_o;
    av[1] = ifb.alloc_v_o; ai[1] = int'(ifb.alloc_idx_o); er[1] = ifb.err_o; vo[1] = int'(ifb.victim_o); vvo[1] = ifb.victim_v_o;
    av[2] = ifc.alloc_v_o; ai[2] = int'(ifc.alloc_idx_o); er[2] = ifc.err_o; vo[2] = int'(ifc.victim_o); vvo[2] = ifc.victim_v_o;
    for (int i = 0; i < 4; i++) ag[0][i] = int'(u4.age_q[i]);
    for (int i = 0; i < 5; i++) ag[1][i] = int'(u5.age_q[i]);
    for (int i = 0; i < 8; i++) ag[2][i] = int'(u8.age_q[i]);
    for (int d = 0; d < 3; d++) begin
      int mv;
      logic [7:0] seen;
      mv = mvictim(d);
      chk($sformatf("victim_v_w%0d", nw(d)), int'(vvo[d]), mv >= 0 ? 1 : 0);
      chk($sformatf("victim_w%0d", nw(d)), vo[d], mv < 0 ? 0 : mv);
      seen = '0;
      for (int k = 0; k < nw(d); k++) begin
        chk($sformatf("age_w%0d_e%0d", nw(d), ord[d][k]), ag[d][ord[d][k]], k);
        if (ag[d][k] < nw(d)) seen[ag[d][k]] = 1'b1;
      end
      chk($sformatf("perm_w%0d", nw(d)), int'(seen), (1 << nw(d)) - 1);
      if (av[d] || er[d]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp w%0d alloc_v=%0d err=%0d idx=%0d", nw(d), av[d], er[d], ai[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!(e.d == d && e.al == av[d] && e.al != er[d] && e.due == cyc && (!e.al || e.idx == ai[d]))) begin
            failures++;
            $display("FAIL resp w%0d actual alloc_v=%0d err=%0d idx=%0d cyc=%0d expected w%0d alloc=%0d idx=%0d cyc=%0d",
                     nw(d), av[d], er[d], ai[d], cyc, nw(e.d), e.al, e.idx, e.due);
          end
        end
      end
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_resp w%0d alloc=%0d idx=%0d due=%0d now=%0d", nw(sb[0].d), sb[0].al, sb[0].idx, sb[0].due, cyc);
      void'(sb.pop_front());
    end
  end
  initial begin
    for (int d = 0; d < 3; d++) begin cv[d] = 1'b0; cop[d] = TOUCH; cidx[d] = 0; lk[d] = '0; end
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_v", int'(ifc.alloc_v_o), 0);
    chk("rst_alloc_idx", int'(ifc.alloc_idx_o), 0);
    chk("rst_err", int'(ifc.err_o), 0);
    chk("rst_victim_w8", int'(ifc.victim_o), 0);
    chk("rst_age7_w8", int'(u8.age_q[7]), 0);
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 4; i++) issue(0, TOUCH, i);
    chk("w4_victim_after_touch", int'(ifa.victim_o), 0);
    chk("w4_victim_v", int'(ifa.victim_v_o), 1);
    issue(0, ALLOC, 0);
    chk("w4_alloc_v", int'(ifa.alloc_v_o), 1);
    chk("w4_alloc_idx", int'(ifa.alloc_idx_o), 0);
    chk("w4_victim_after_alloc", int'(ifa.victim_o), 1);
    @(posedge clk); #1;
    chk("w4_alloc_pulse_end", int'(ifa.alloc_v_o), 0);
    chk("w4_alloc_idx_held", int'(ifa.alloc_idx_o), 0);
    do_reset();
    for (int i = 0; i < 4; i++) issue(0, TOUCH, i);
    issue(0, INVAL, 3);
    chk("w4_inval3", int'(ifa.victim_o), 3);
    issue(0, TOUCH, 3);
    chk("w4_touch3", int'(ifa.victim_o), 0);
    issue(0, INVAL, 0);
    chk("w4_inval_lru", int'(ifa.victim_o), 0);
    chk("w4_inval_lru_age", int'(u4.age_q[0]), 3);
    lk[2] = 8'h01; #1;
    chk("w8_lock0_victim", int'(ifc.victim_o), 1);
    lk[2] = 8'hFF; #1;
    chk("w8_all_locked_v", int'(ifc.victim_v_o), 0);
    chk("w8_all_locked_idx", int'(ifc.victim_o), 0);
    issue(2, ALLOC, 0);
    chk("w8_alloc_locked_err", int'(ifc.err_o), 1);
    chk("w8_alloc_locked_nogrant", int'(ifc.alloc_v_o), 0);
    lk[2] = 8'h00;
    issue(1, TOUCH, 6);
    chk("w5_bad_idx_err", int'(ifb.err_o), 1);
    for (int k = 0; k < 4; k++) begin
      issue(1, ALLOC, 0);
      chk($sformatf("w5_grant%0d_v", k), int'(ifb.alloc_v_o), 1);
      chk($sformatf("w5_grant%0d", k), int'(ifb.alloc_idx_o), k);
    end
    chk("w5_victim_after_allocs", int'(ifb.victim_o), 4);
    issue(1, RSVD, 2);
    chk("w5_rsvd_err", int'(ifb.err_o), 1);
    issue(0, TOUCH, 0);
    cv[0] = 1'b1; cop[0] = ALLOC; rst = 1'b0;
    @(posedge clk); #1;
    mreset();
    rst = 1'b1; cv[0] = 1'b0;
    chk("rst_alloc_dropped", int'(ifa.alloc_v_o), 0);
    chk("rst_alloc_no_err", int'(ifa.err_o), 0);
    chk("rst_alloc_victim", int'(ifa.victim_o), 0);
    issue(2, TOUCH, 0);
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst = 1'b0;
    #30;
    chk("stopped_clk_victim", int'(ifc.victim_o), 1);
    chk("stopped_clk_age0", int'(u8.age_q[0]), 0);
    clk_en = 1'b1;
    @(posedge clk); #1;
    mreset();
    rst = 1'b1;
    chk("restart_reset_victim", int'(ifc.victim_o), 0);
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 150; n++) begin
        lk[d] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end else begin
          issue(d, lru_op_e'($urandom_range(0, 3)), $urandom_range(0, d == 0 ? 3 : 7));
        end
      end
      lk[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
